// File: rtl/pipe_flow_ctrl.sv
// pipe_flow_ctrl
//   Credit-based flow control around an external L-stage, clock-enabled
//   datapath delay pipe. Items accepted upstream travel the pipe alongside a
//   valid shift register and land in a D-deep first-word-fall-through FIFO.
//   Intake is limited so that in-flight plus buffered items never exceed D.
//   A drain request stops intake until the block is empty, then pulses
//   drain_done and resumes.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready upstream handshake; data goes straight to the datapath
//   pipe_ce           clock enable for the datapath delay pipe
//   pipe_out_data     datapath output, captured when the last stage is valid
//   out_valid/ready   downstream handshake on the FIFO head
//   out_data          FIFO head (first-word-fall-through)
//   drain_req         stop intake and empty the block
//   drain_done        one-cycle pulse when a drain completes
//   occupancy         in-flight items plus FIFO items (registered)
//   stat_accept       accepted-item counter (saturating)
//   stat_stall        cycles with in_valid & !in_ready (saturating)
//
// Configuration
//   PIPE_FLOW_STATS_EN  when defined, builds the statistics counters;
//                       otherwise stat_accept/stat_stall are tied to 0.

module pipe_flow_ctrl #(
    parameter int W  = 32,
    parameter int L  = 4,
    parameter int D  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          pipe_ce,
    input  logic [W-1:0]  pipe_out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    input  logic          drain_req,
    output logic          drain_done,
    output logic [CW-1:0] occupancy,
    output logic [31:0]   stat_accept,
    output logic [31:0]   stat_stall
);

    localparam int PW = (D > 1) ? $clog2(D) : 1;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          drain_done_q, drain_done_d;
    logic [L-1:0]  vs_q, vs_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [W-1:0]  mem_q [D];

    logic in_fire;
    logic out_fire;
    logic fifo_wr;

    // Credit check uses only registered occupancy, so a pop frees its
    // credit one cycle later. rst_n gating keeps in_ready low during reset.
    assign in_ready  = rst_n & (state_q == RUN) & (occ_q < CW'(D));
    assign in_fire   = in_valid & in_ready;
    assign out_valid = (cnt_q != '0);
    assign out_fire  = out_valid & out_ready;
    assign out_data  = mem_q[rd_ptr_q];

    // The pipe only needs to move while it carries something or takes a
    // new item; it freezes when empty.
    assign pipe_ce = in_fire | (|vs_q);

    // Last stage valid implies pipe_ce is high, so each item is written once.
    assign fifo_wr = vs_q[L-1];

    assign occupancy  = occ_q;
    assign drain_done = drain_done_q;

    always_comb begin
        vs_d = vs_q;
        if (pipe_ce) begin
            vs_d[0] = in_fire;
            for (int unsigned i = 1; i < L; i++) begin
                vs_d[i] = vs_q[i-1];
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (fifo_wr) begin
            wr_ptr_d = (wr_ptr_q == PW'(D - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (out_fire) begin
            rd_ptr_d = (rd_ptr_q == PW'(D - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
    end

    always_comb begin
        unique case ({fifo_wr, out_fire})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Occupancy is registered from next-state values so it always equals
    // popcount(vs) + FIFO count of the current cycle.
    always_comb begin
        occ_d = cnt_d;
        for (int unsigned i = 0; i < L; i++) begin
            occ_d = occ_d + CW'(vs_d[i]);
        end
    end

    always_comb begin
        state_d      = state_q;
        drain_done_d = 1'b0;
        unique case (state_q)
            RUN: begin
                if (drain_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (occ_q == '0) begin
                    state_d      = RUN;
                    drain_done_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            drain_done_q <= 1'b0;
            vs_q         <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            occ_q        <= '0;
        end else begin
            state_q      <= state_d;
            drain_done_q <= drain_done_d;
            vs_q         <= vs_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            occ_q        <= occ_d;
        end
    end

    // Storage is not reset; the cleared pointers and count make stale
    // contents unreachable.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem_q[wr_ptr_q] <= pipe_out_data;
        end
    end

`ifdef PIPE_FLOW_STATS_EN
    logic [31:0] stat_accept_q, stat_accept_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    always_comb begin
        stat_accept_d = stat_accept_q;
        stat_stall_d  = stat_stall_q;
        if (in_fire && (stat_accept_q != '1)) begin
            stat_accept_d = stat_accept_q + 32'd1;
        end
        if (in_valid && !in_ready && (stat_stall_q != '1)) begin
            stat_stall_d = stat_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_accept_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_accept_q <= stat_accept_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_accept = stat_accept_q;
    assign stat_stall  = stat_stall_q;
`else
    assign stat_accept = '0;
    assign stat_stall  = '0;
`endif

endmodule

// File: doc/pipe_flow_ctrl.md
PIPE_FLOW_CTRL -- requirements
Module: pipe_flow_ctrl

Interface
REQ-001 Parameters SHALL be: W, 32, data width; L, 4, ce-gated register stages from datapath input to pipe_out_data (L>=1); D, 8, credit limit and FIFO depth (D>=1); CW, 4, count width (2^CW > D).
REQ-002 Ports SHALL be, in order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream item offered; its data goes directly to the datapath.
- in_ready  out  1  item may be accepted this cycle.
- pipe_ce  out  1  clock enable for the datapath delay pipe.
- pipe_out_data  in  W  datapath output.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts the head.
- out_data  out  W  FIFO head, first-word-fall-through.
- drain_req  in  1  request to stop intake and empty the block.
- drain_done  out  1  one-cycle pulse when a drain completes.
- occupancy  out  CW  in-flight items plus FIFO items.
- stat_accept  out  32  accepted-item counter.
- stat_stall  out  32  stall-cycle counter.

Function
REQ-003 in_fire SHALL equal in_valid & in_ready; out_fire SHALL equal out_valid & out_ready.
REQ-004 An L-bit valid shift register vs SHALL advance only when pipe_ce=1: vs[0] <= in_fire, vs[i] <= vs[i-1].
REQ-005 pipe_ce SHALL equal in_fire | (OR of vs); the pipe freezes only when it holds no valid item.
REQ-006 When vs[L-1]=1, pipe_out_data SHALL be written into the FIFO at that rising edge, exactly once per item.
REQ-007 Items SHALL leave in acceptance order; latency from in_fire to out_valid SHALL be L+1 cycles with pipe_ce continuously high.
REQ-008 occupancy SHALL be popcount(vs) + FIFO count, registered, and SHALL never exceed D.
REQ-009 in_ready SHALL be (state==RUN) & (occupancy<D), decoded from registers only, never combinationally from out_ready.
REQ-010 A FIFO pop in the same cycle as an acceptance SHALL free its credit only from the next cycle.
REQ-011 A simultaneous FIFO write and pop SHALL leave the FIFO count unchanged; write and read pointers SHALL wrap modulo D.
REQ-012 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-013 The state machine SHALL have two states, RUN and DRAIN; RUN->DRAIN when drain_req=1.
REQ-014 DRAIN->RUN SHALL occur when occupancy==0, with drain_done=1 for exactly that cycle.
REQ-015 drain_req asserted with occupancy already 0 SHALL give DRAIN for one cycle, then the drain_done pulse.
REQ-016 During DRAIN, in-flight items SHALL still advance and enter the FIFO, and out_valid/out_ready SHALL operate normally.
REQ-017 Sustained throughput of 1 item/cycle SHALL be achieved when D>=L+2 and out_ready=1.

Reset
REQ-018 rst_n=0 SHALL immediately clear vs, the FIFO pointers and count, and the stats, and force state RUN and drain_done=0.
REQ-019 During reset, in_ready, out_valid, pipe_ce and occupancy SHALL read 0.
REQ-020 Reset mid-operation SHALL discard all in-flight and buffered items; FIFO data storage need not be cleared.

Configuration
REQ-021 With macro PIPE_FLOW_STATS_EN defined, stat_accept SHALL count in_fire and stat_stall SHALL count cycles with in_valid & !in_ready; both saturate at 2^32-1.
REQ-022 Without PIPE_FLOW_STATS_EN, stat_accept and stat_stall SHALL be constant 0, no counter logic SHALL be built, and all other behaviour SHALL be identical.

Verification
REQ-023 Latency: L=4, D=6, single item 0xA5 accepted at cycle 0 with out_ready=1 -> out_valid=1, out_data=0xA5 at cycle 5; pipe_ce returns to 0 after the item reaches the FIFO.
REQ-024 Stream: L=4, D=6, 100 back-to-back items 0..99 with out_ready=1 -> in_ready never drops, outputs 0..99 in order, stat_accept=100.
REQ-025 Backpressure: L=4, D=8, out_ready=0 and in_valid=1 -> exactly 8 accepted, in_ready=0, occupancy=8, stat_stall increments each cycle; releasing out_ready gives in_ready=1 one cycle after the first pop.
REQ-026 Drain: D=8, 3 items in flight, drain_req pulsed, out_ready=1 -> in_ready=0 until all 3 items are delivered, drain_done pulses once with occupancy=0, then RUN.
REQ-027 Reset: rst_n pulled low asynchronously with 5 items buffered -> out_valid and occupancy go to 0 before the next clock edge, and no stale item appears after release.
